stack_drain_ctrl: RTL and testbench

//  Read-side controller for the Stack LIFO: on a start command it pops up to

---
 rtl/stack_drain_ctrl.sv | 115 +++++++++++
 tb/tb_stack_drain_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_drain_ctrl.sv
// rtl/stack_drain_ctrl.sv - Stack LIFO read-side burst drain controller
// Pops up to burst_len words, one outstanding at a time, onto a valid/ready stream.
module stack_drain_ctrl #(
    parameter int BANDWIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = $clog2(DEPTH + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 abort,
    input  logic                 stk_empty,
    input  logic [BANDWIDTH-1:0] stk_data,
    output logic                 stk_pop,
    output logic [BANDWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     popped_cnt,
    output logic                 underflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_S  = 3'd2,
        PRESENT = 3'd3,
        DONE_S  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len;
    logic             abort_pend;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = popped_cnt + CNT_W'(1);

    // Pop is decoded from state so the strobe lands in the ISSUE cycle itself,
    // giving the ISSUE/WAIT/PRESENT three-cycle word rate; async reset kills it at once.
    assign stk_pop = (state == ISSUE) && !abort && !abort_pend && !stk_empty;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            len        <= '0;
            abort_pend <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            popped_cnt <= '0;
            underflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        popped_cnt <= '0;
                        underflow  <= 1'b0;
                        if (burst_len != '0) begin
                            len   <= burst_len;
                            state <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE_S;
                        end
                    end
                end
                ISSUE: begin
                    if (abort || abort_pend) begin
                        done  <= 1'b1;
                        state <= DONE_S;
                    end else if (stk_empty) begin
                        underflow <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE_S;
                    end else begin
                        state <= WAIT_S;
                    end
                end
                WAIT_S: begin
                    out_data  <= stk_data;
                    out_valid <= 1'b1;
                    if (abort) abort_pend <= 1'b1;
                    state <= PRESENT;
                end
                PRESENT: begin
                    // The word in flight is always delivered; abort only stops further pops.
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        popped_cnt <= cnt_next;
                        if ((cnt_next == len) || abort_pend || abort) begin
                            done  <= 1'b1;
                            state <= DONE_S;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                DONE_S: begin
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_drain_ctrl.sv
// tb/tb_stack_drain_ctrl.sv - self-checking bench for stack_drain_ctrl
// Table vectors, reset corner sequences and random bursts against a LIFO model.
module tb_stack_drain_ctrl;
    localparam int BW    = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;

    logic             clk = 1'b0;
    logic             rstn, start, abort, stk_empty, out_ready;
    logic             stk_pop, out_valid, busy, done, underflow;
    logic [CNT_W-1:0] burst_len, popped_cnt;
    logic [BW-1:0]    stk_data, out_data;

    stack_drain_ctrl #(.BANDWIDTH(BW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .burst_len(burst_len), .abort(abort),
        .stk_empty(stk_empty), .stk_data(stk_data), .stk_pop(stk_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .popped_cnt(popped_cnt), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stack model: mem[0..stk_n-1], top at stk_n-1; data_out updates after a sampled pop.
    logic [BW-1:0] mem [0:31];
    int            stk_n;
    assign stk_empty = (stk_n == 0);

    int            c, pops, dones, done_c;
    int            pop_c[$];
    logic [BW-1:0] got[$];

    typedef struct {
        int fill;
        int len;
        int mode;
        int abort_word;
        int exp_cnt;
        bit exp_uf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic p;
        @(negedge clk);
        c++;
        p = stk_pop;
        if (p) begin
            pops++;
            chk("pop_while_empty", {31'd0, stk_empty}, 0);
            chk("pop_while_valid", {31'd0, out_valid}, 0);
            if (pop_c.size() > 0) chk("pop_spacing_ge3", (c - pop_c[$]) >= 3, 1);
            pop_c.push_back(c);
        end
        if (done) begin
            if (dones == 0) done_c = c;
            dones++;
        end
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        #1;
        if (p && stk_n > 0) begin
            stk_n--;
            stk_data = mem[stk_n];
        end
    endtask

    task automatic fill_stack(input int n, input bit rnd);
        stk_n = 0;
        for (int i = 0; i < n; i++) begin
            mem[i] = rnd ? BW'($urandom) : BW'(i);
            stk_n++;
        end
    endtask

    task automatic run_burst(input int len, input int mode, input int abort_word, input string tag);
        logic [BW-1:0] exp_w[$];
        logic [BW-1:0] held;
        int            n, size, t, stall;
        bit            exp_uf, aborts;
        size   = stk_n;
        aborts = (abort_word > 0) && (abort_word <= size) && (abort_word <= len);
        n      = (len < size) ? len : size;
        if (aborts && abort_word < n) n = abort_word;
        exp_uf = (len > size) && !aborts;
        for (int i = 0; i < n; i++) exp_w.push_back(mem[size - 1 - i]);
        got.delete();
        pop_c.delete();
        pops = 0; dones = 0; done_c = 0; c = 0; t = 0; stall = 0; held = '0;

        start = 1'b1; burst_len = CNT_W'(len); abort = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (dones == 0 && t < 300) begin
            abort     = (abort_word > 0) && out_valid && (got.size() == abort_word - 1);
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && out_valid && got.size() == 1 && stall < 5) begin
                if (stall == 0) held = out_data;
                else begin
                    chk({tag, "_stall_data"}, {28'd0, out_data}, {28'd0, held});
                    chk({tag, "_stall_valid"}, {31'd0, out_valid}, 1);
                end
                out_ready = 1'b0;
                stall++;
            end
            tick();
            t++;
        end
        abort = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 0);
        chk({tag, "_popped_cnt"}, {27'd0, popped_cnt}, n);
        chk({tag, "_underflow"}, {31'd0, underflow}, {31'd0, exp_uf});
        chk({tag, "_pop_count"}, pops, n);
        chk({tag, "_word_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk({tag, "_word"}, {28'd0, got[i]}, {28'd0, exp_w[i]});
        if (len > 0 && size > 0 && pop_c.size() > 0) chk({tag, "_first_pop_cycle"}, pop_c[0], 2);
        if (len == 0) chk({tag, "_len0_done_cycle"}, done_c, 2);
        if (mode == 0)
            for (int i = 1; i < pop_c.size(); i++)
                chk({tag, "_pop_spacing_eq3"}, pop_c[i] - pop_c[i-1], 3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{8, 8,  0, 0, 8, 1'b0};
        vecs[1] = '{8, 8,  2, 0, 8, 1'b0};
        vecs[2] = '{3, 5,  0, 0, 3, 1'b1};
        vecs[3] = '{8, 8,  0, 4, 4, 1'b0};
        vecs[4] = '{5, 0,  0, 0, 0, 1'b0};
        vecs[5] = '{0, 3,  0, 0, 0, 1'b1};
        vecs[6] = '{8, 12, 1, 0, 8, 1'b1};
        vecs[7] = '{6, 2,  1, 0, 2, 1'b0};

        rstn = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        burst_len = '0; stk_n = 0; stk_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stk_pop", {31'd0, stk_pop}, 0);
        chk("rst_out_data", {28'd0, out_data}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_popped_cnt", {27'd0, popped_cnt}, 0);
        chk("rst_underflow", {31'd0, underflow}, 0);
        rstn = 1'b0;
        tick();

        foreach (vecs[i]) begin
            fill_stack(vecs[i].fill, 1'b0);
            run_burst(vecs[i].len, vecs[i].mode, vecs[i].abort_word, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tab_cnt", i), {27'd0, popped_cnt}, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_tab_uf", i), {31'd0, underflow}, {31'd0, vecs[i].exp_uf});
        end

        // Async reset while the pop strobe is high.
        fill_stack(4, 1'b0);
        start = 1'b1; burst_len = CNT_W'(2);
        tick();
        start = 1'b0;
        chk("pop_before_rst", {31'd0, stk_pop}, 1);
        rstn = 1'b1;
        #1;
        chk("pop_drops_async", {31'd0, stk_pop}, 0);
        chk("busy_drops_async", {31'd0, busy}, 0);
        #1;
        rstn = 1'b0;
        tick();
        chk("idle_after_rst_pop", {31'd0, stk_pop}, 0);

        // Async reset in WAIT, then a fresh two-word burst.
        fill_stack(6, 1'b0);
        start = 1'b1; burst_len = CNT_W'(4);
        tick();
        start = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("wait_rst_busy", {31'd0, busy}, 0);
        chk("wait_rst_valid", {31'd0, out_valid}, 0);
        chk("wait_rst_pop", {31'd0, stk_pop}, 0);
        #1;
        rstn = 1'b0;
        tick();
        run_burst(2, 0, 0, "post_rst");

        for (int r = 0; r < 25; r++) begin
            int f, l, m, a;
            f = $urandom_range(0, DEPTH);
            l = $urandom_range(0, DEPTH + 4);
            m = $urandom_range(0, 1);
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            fill_stack(f, 1'b1);
            run_burst(l, m, a, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
